// File: rtl/fadd_issue.sv
// fadd_issue: two-stage issue/retire wrapper around the combinational
// single-precision adder `fadd`.
//   Stage 1 (S1) registers the accepted op. For FSUB it flips the sign of b.
//   S1 drives fadd_x1/fadd_x2 directly from its operand registers.
//   Stage 2 (S2) captures the adder result, or a locally computed
//   sign-injection result, and presents it on out_*.
// Ports:
//   clk, rst                   clock, async active-high reset
//   in_valid/in_ready          op handshake; in_op/in_a/in_b/in_tag payload
//   fadd_x1/fadd_x2            operands to the external adder
//   fadd_y/fadd_ovf            adder result and overflow (combinational)
//   out_valid/out_ready        result handshake
//   out_data/out_tag           result payload
//   out_ovf/out_illegal        per-result status
//   ovf_sticky/clr_flags       sticky overflow flag and its clear
module fadd_issue #(
  parameter int unsigned TAG_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [31:0]       in_a,
  input  logic [31:0]       in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [31:0]       fadd_x1,
  output logic [31:0]       fadd_x2,
  input  logic [31:0]       fadd_y,
  input  logic              fadd_ovf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_ovf,
  output logic              out_illegal,
  output logic              ovf_sticky,
  input  logic              clr_flags
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_FADD   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_FSUB   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_FSGNJ  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_FSGNJN = OP_W'(3);
  localparam logic [OP_W-1:0] OP_FSGNJX = OP_W'(4);

  // Stage 1 registers
  logic              s1_valid_q, s1_valid_d;
  logic [OP_W-1:0]   s1_op_q,    s1_op_d;
  logic [TAG_W-1:0]  s1_tag_q,   s1_tag_d;
  logic [DATA_W-1:0] s1_a_q,     s1_a_d;
  logic [DATA_W-1:0] s1_b_q,     s1_b_d;

  // Stage 2 registers
  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_data_q,  s2_data_d;
  logic [TAG_W-1:0]  s2_tag_q,   s2_tag_d;
  logic              s2_ovf_q,   s2_ovf_d;
  logic              s2_ill_q,   s2_ill_d;

  logic              sticky_q,   sticky_d;

  // Handshake control
  logic              adv1;
  logic              accept;
  logic              retire;

  // Result computed from S1 contents, captured into S2 on advance
  logic [DATA_W-1:0] res_data;
  logic              res_ovf;
  logic              res_ill;

  // S1 may hand off whenever S2 is empty or S2 is retiring this cycle
  assign adv1     = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || adv1;
  assign accept   = in_valid && in_ready;
  assign retire   = s2_valid_q && out_ready;

  assign fadd_x1  = s1_a_q;
  assign fadd_x2  = s1_b_q;

  // Stage 1 next state: load on accept, otherwise drain when handed off
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_tag_d   = s1_tag_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = in_op;
      s1_tag_d   = in_tag;
      s1_a_d     = in_a;
      // FSUB becomes an FADD of -b
      s1_b_d     = (in_op == OP_FSUB) ? {~in_b[31], in_b[30:0]} : in_b;
    end else if (adv1) begin
      s1_valid_d = 1'b0;
    end
  end

  // Result selection for the op held in S1
  always_comb begin
    res_data = '0;
    res_ovf  = 1'b0;
    res_ill  = 1'b0;
    case (s1_op_q)
      OP_FADD, OP_FSUB: begin
        res_data = fadd_y;
        res_ovf  = fadd_ovf;
      end
      OP_FSGNJ:  res_data = {s1_b_q[31], s1_a_q[30:0]};
      OP_FSGNJN: res_data = {~s1_b_q[31], s1_a_q[30:0]};
      OP_FSGNJX: res_data = {s1_a_q[31] ^ s1_b_q[31], s1_a_q[30:0]};
      default:   res_ill  = 1'b1;
    endcase
  end

  // Stage 2 next state: payload only changes when a valid op moves in,
  // so out_* stay stable under backpressure
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_tag_d   = s2_tag_q;
    s2_ovf_d   = s2_ovf_q;
    s2_ill_d   = s2_ill_q;
    if (adv1) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = res_data;
        s2_tag_d  = s1_tag_q;
        s2_ovf_d  = res_ovf;
        s2_ill_d  = res_ill;
      end
    end
  end

  // Sticky overflow: a set on retire takes priority over a clear
  always_comb begin
    sticky_d = sticky_q;
    if (retire && s2_ovf_q) begin
      sticky_d = 1'b1;
    end else if (clr_flags) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_tag_q   <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_tag_q   <= '0;
      s2_ovf_q   <= 1'b0;
      s2_ill_q   <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_tag_q   <= s1_tag_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_tag_q   <= s2_tag_d;
      s2_ovf_q   <= s2_ovf_d;
      s2_ill_q   <= s2_ill_d;
      sticky_q   <= sticky_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_data    = s2_data_q;
  assign out_tag     = s2_tag_q;
  assign out_ovf     = s2_ovf_q;
  assign out_illegal = s2_ill_q;
  assign ovf_sticky  = sticky_q;

endmodule

// File: tb/tb_fadd_issue.sv
// Testbench for fadd_issue. A stand-in for the external adder answers the
// operand pairs used below. Expected results are queued when an op is
// accepted and compared when the DUT retires it.
module tb_fadd_issue;

  localparam int unsigned TAG_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [31:0]       in_a;
  logic [31:0]       in_b;
  logic [TAG_W-1:0]  in_tag;
  logic [31:0]       fadd_x1;
  logic [31:0]       fadd_x2;
  logic [31:0]       fadd_y;
  logic              fadd_ovf;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_ovf;
  logic              out_illegal;
  logic              ovf_sticky;
  logic              clr_flags;

  typedef struct packed {
    logic [31:0]      d;
    logic [TAG_W-1:0] tag;
    logic             ovf;
    logic             ill;
  } exp_t;

  exp_t sb[$];
  exp_t cur_exp;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fadd_issue #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .fadd_x1    (fadd_x1),
    .fadd_x2    (fadd_x2),
    .fadd_y     (fadd_y),
    .fadd_ovf   (fadd_ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .out_ovf    (out_ovf),
    .out_illegal(out_illegal),
    .ovf_sticky (ovf_sticky),
    .clr_flags  (clr_flags)
  );

  // Stand-in for the combinational adder: known sums, else an integer sum
  always_comb begin
    fadd_ovf = 1'b0;
    case ({fadd_x1, fadd_x2})
      {32'h3F80_0000, 32'h4000_0000}: fadd_y = 32'h4040_0000;
      {32'h4040_0000, 32'hBF80_0000}: fadd_y = 32'h4000_0000;
      {32'h7F7F_FFFF, 32'h7F7F_FFFF}: begin
        fadd_y   = 32'h7F80_0000;
        fadd_ovf = 1'b1;
      end
      default: fadd_y = fadd_x1 + fadd_x2;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input logic [31:0] ed,
                       input logic eo, input logic ei);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    cur_exp  = '{d: ed, tag: tag, ovf: eo, ill: ei};
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_op    = 3'd0;
    in_a     = 32'h0;
    in_b     = 32'h0;
    in_tag   = '0;
  endtask

  // One clock: record handshakes just before the edge, then return at negedge
  task automatic step();
    exp_t e;
    #1;
    if (in_valid && in_ready) sb.push_back(cur_exp);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result_sb_size", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_tag", 32'(out_tag), 32'(e.tag));
        chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
        chk("out_illegal", 32'(out_illegal), 32'(e.ill));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] snap;

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    clr_flags = 1'b0;
    cur_exp   = '0;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_out_illegal", 32'(out_illegal), 32'd0);
    chk("rst_sticky", 32'(ovf_sticky), 32'd0);
    chk("rst_fadd_x1", fadd_x1, 32'h0);
    chk("rst_fadd_x2", fadd_x2, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // FADD: latency two edges
    out_ready = 1'b1;
    drive(3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd3, 32'h4040_0000, 1'b0, 1'b0);
    step();
    idle();
    chk("fadd_lat_s1_out_valid", 32'(out_valid), 32'd0);
    step();
    chk("fadd_lat_s2_out_valid", 32'(out_valid), 32'd1);
    step();

    // FSUB: sign of b flipped on the adder input
    drive(3'd1, 32'h4040_0000, 32'h3F80_0000, 5'd4, 32'h4000_0000, 1'b0, 1'b0);
    step();
    idle();
    chk("fsub_fadd_x1", fadd_x1, 32'h4040_0000);
    chk("fsub_fadd_x2", fadd_x2, 32'hBF80_0000);
    step();
    step();

    // Sign injection and illegal, back to back
    drive(3'd3, 32'h3F80_0000, 32'h0000_0000, 5'd5, 32'hBF80_0000, 1'b0, 1'b0);
    step();
    drive(3'd4, 32'hC000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 1'b0, 1'b0);
    step();
    drive(3'd6, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7, 32'h0, 1'b0, 1'b1);
    step();
    idle();
    step();
    step();
    chk("sgn_drained_out_valid", 32'(out_valid), 32'd0);

    // Backpressure: two ops fill the pipe, third stalls
    out_ready = 1'b0;
    drive(3'd2, 32'h3F80_0000, 32'h8000_0000, 5'd1, 32'hBF80_0000, 1'b0, 1'b0);
    step();
    drive(3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd2, 32'h4040_0000, 1'b0, 1'b0);
    step();
    drive(3'd3, 32'h4000_0000, 32'h8000_0000, 5'd3, 32'h4000_0000, 1'b0, 1'b0);
    #1;
    chk("bp_in_ready_full", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_out_tag", 32'(out_tag), 32'd1);
    snap = out_data;
    step();
    step();
    chk("bp_out_data_stable", out_data, snap);
    chk("bp_out_tag_stable", 32'(out_tag), 32'd1);
    chk("bp_in_ready_still", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    idle();
    chk("bp_rel_valid2", 32'(out_valid), 32'd1);
    chk("bp_rel_tag2", 32'(out_tag), 32'd2);
    step();
    chk("bp_rel_valid3", 32'(out_valid), 32'd1);
    chk("bp_rel_tag3", 32'(out_tag), 32'd3);
    step();
    chk("bp_rel_empty", 32'(out_valid), 32'd0);

    // Overflow sets the sticky flag on retire
    drive(3'd0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 5'd9, 32'h7F80_0000, 1'b1, 1'b0);
    step();
    idle();
    step();
    chk("ovf_sticky_before_retire", 32'(ovf_sticky), 32'd0);
    step();
    chk("ovf_sticky_set", 32'(ovf_sticky), 32'd1);

    // Set and clear in the same cycle: set wins
    drive(3'd0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 5'd10, 32'h7F80_0000, 1'b1, 1'b0);
    step();
    idle();
    step();
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("ovf_set_wins", 32'(ovf_sticky), 32'd1);

    // Async reset with two ops in flight
    out_ready = 1'b0;
    drive(3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd11, 32'h4040_0000, 1'b0, 1'b0);
    step();
    drive(3'd2, 32'h3F80_0000, 32'h8000_0000, 5'd12, 32'hBF80_0000, 1'b0, 1'b0);
    step();
    idle();
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_sticky", 32'(ovf_sticky), 32'd0);
    chk("async_rst_fadd_x1", fadd_x1, 32'h0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_no_stale", 32'(out_valid), 32'd0);
    end

    // Lone clear drops the flag
    drive(3'd1, 32'h7F7F_FFFF, 32'hFF7F_FFFF, 5'd13, 32'h7F80_0000, 1'b1, 1'b0);
    step();
    idle();
    step();
    step();
    chk("ovf_sticky_reset_again", 32'(ovf_sticky), 32'd1);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("lone_clr", 32'(ovf_sticky), 32'd0);

    // Drain whatever remains, bounded
    for (int i = 0; i < 20 && sb.size() > 0; i++) step();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fadd_issue.md
Name: fadd_issue

Overview:
- Pipelined issue/retire wrapper that sits directly upstream and downstream of the combinational single-precision adder `fadd`.
- Accepts FP add-class ops from the core over a valid/ready handshake, and pre-conditions operands (sign flip for FSUB).
- Drives `fadd` from registered operands, executes sign-injection ops locally, and returns results in order with a one-entry-per-stage 2-stage pipeline.
- Keeps a sticky overflow status flag.

Parameters:
- TAG_W, 5, width of the destination-register tag carried alongside each op.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  op present on in_* this cycle.
- in_ready  out  1  block accepts the op this cycle.
- in_op  in  3  0=FADD, 1=FSUB, 2=FSGNJ, 3=FSGNJN, 4=FSGNJX, 5..7 illegal.
- in_a  in  32  operand a (IEEE-754 single).
- in_b  in  32  operand b.
- in_tag  in  TAG_W  destination tag.
- fadd_x1  out  32  to `fadd` first operand.
- fadd_x2  out  32  to `fadd` second operand.
- fadd_y  in  32  `fadd` result (combinational from x1/x2).
- fadd_ovf  in  1  `fadd` overflow.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes the result.
- out_data  out  32  result.
- out_tag  out  TAG_W  tag of the result.
- out_ovf  out  1  this result overflowed (FADD/FSUB only).
- out_illegal  out  1  op was illegal.
- ovf_sticky  out  1  sticky overflow status.
- clr_flags  in  1  clears ovf_sticky.

Behaviour:
- Reset (async, any time, including mid-operation):
  - s1_valid=0, s2_valid=0; all in-flight ops are dropped.
  - out_valid=0, out_data=0, out_tag=0, out_ovf=0, out_illegal=0, ovf_sticky=0.
  - S1 operand registers=0, so fadd_x1=fadd_x2=0.
  - in_ready=1 on the first cycle after reset deassertion.
- Handshake:
  - A transfer occurs on a rising edge with valid&ready.
  - in_ready = !s1_valid | adv1.
  - adv1 = !s2_valid | out_ready.
  - in_ready is combinational from out_ready; no combinational path from in_valid to any output.
- Stage 1 (accept):
  - Register op, tag, a → s1_a.
  - b → s1_b, with bit 31 inverted when op=FSUB, unchanged otherwise.
  - fadd_x1=s1_a, fadd_x2=s1_b at all times.
  - When adv1=1 and no new input arrives, s1_valid clears.
- Stage 2 (retire), loaded from S1 when s1_valid & adv1:
  - FADD/FSUB: data=fadd_y, ovf=fadd_ovf.
  - FSGNJ: {s1_b[31], s1_a[30:0]}.
  - FSGNJN: {~s1_b[31], s1_a[30:0]}.
  - FSGNJX: {s1_a[31]^s1_b[31], s1_a[30:0]}.
  - Sign-injection ops: ovf=0, illegal=0.
  - Illegal ops: data=0, illegal=1, ovf=0.
  - out_* reflect the S2 registers directly.
- Latency and ordering:
  - Accept at edge N → out_valid high after edge N+1.
  - Throughput 1 op/cycle with out_ready held high.
  - Strict in-order completion.
- Backpressure:
  - With out_ready=0, S2 holds its contents and S1 holds if full.
  - Capacity is 2 ops; in_ready=0 while both stages are full.
  - out_* stay stable while out_valid=1 & out_ready=0.
- Sticky flag:
  - ovf_sticky sets on the S2 retire handshake (out_valid & out_ready) when out_ovf=1.
  - clr_flags clears it.
  - If set and clear occur in the same cycle, set wins.
- Simultaneous events: accept into S1, S1→S2 move, and S2 retire may all occur in one cycle.

Test Plan:
- Reset then FADD a=0x3F800000, b=0x40000000, tag=3, out_ready=1 → out_valid 2 cycles later, out_data=0x40400000, out_tag=3, out_ovf=0.
- FSUB a=0x40400000, b=0x3F800000 → fadd_x2=0xBF800000 while in S1; out_data=0x40000000.
- FSGNJN a=0x3F800000, b=0x00000000 → 0xBF800000. FSGNJX a=0xC0000000, b=0x80000000 → 0x40000000. op=6 → out_data=0, out_illegal=1.
- Backpressure: out_ready=0, issue tags 1,2,3 back-to-back → in_ready=0 after 2 accepts, outputs stable. Release out_ready → tags retire 1,2,3 in consecutive cycles with correct data.
- Overflow: FADD 0x7F7FFFFF + 0x7F7FFFFF → out_ovf=1, ovf_sticky=1 after retire. clr_flags pulse in the same cycle as a second overflow retire → stays 1. Lone clr_flags → 0.
- Assert rst with 2 ops in flight → out_valid=0 and ovf_sticky=0 immediately (asynchronously). After release, no stale results appear and in_ready=1.
